// File: rtl/mac32_issue_if.sv
// mac32_issue_if: request, operand, datapath and response bundle around the MAC32 issue controller
interface mac32_issue_if #(parameter int PARM_RM = 3, parameter int PARM_XLEN = 32);
  logic                 req_i;
  logic [PARM_RM-1:0]   Rounding_mode_i;
  logic [PARM_XLEN-1:0] A_i, B_i, C_i;
  logic                 ready_o;
  logic                 stall_i;
  logic [PARM_RM-1:0]   Rounding_mode_o;
  logic [PARM_XLEN-1:0] A_o, B_o, C_o;
  logic [PARM_XLEN-1:0] Result_i;
  logic                 NV_i, OF_i, UF_i, NX_i;
  logic                 valid_o;
  logic [PARM_XLEN-1:0] Result_o;
  logic [4:0]           flags_o;
  logic                 fflags_clr_i;
  logic [4:0]           fflags_o;
  modport master (
    output req_i, Rounding_mode_i, A_i, B_i, C_i, stall_i, Result_i, NV_i, OF_i, UF_i, NX_i, fflags_clr_i,
    input  ready_o, Rounding_mode_o, A_o, B_o, C_o, valid_o, Result_o, flags_o, fflags_o
  );
  modport slave (
    input  req_i, Rounding_mode_i, A_i, B_i, C_i, stall_i, Result_i, NV_i, OF_i, UF_i, NX_i, fflags_clr_i,
    output ready_o, Rounding_mode_o, A_o, B_o, C_o, valid_o, Result_o, flags_o, fflags_o
  );
endinterface

// File: rtl/mac32_issue_ctrl.sv
// mac32_issue_ctrl: registers FMA requests, waits PARM_LAT settle cycles, captures result/flags with valid/stall and sticky fflags
module mac32_issue_ctrl #(
  parameter int PARM_RM   = 3,
  parameter int PARM_XLEN = 32,
  parameter int PARM_LAT  = 2
) (
  input logic clk,
  input logic rst_n,
  mac32_issue_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       accept;
  logic [4:0] new_flags;
  assign bus.ready_o = !bus.stall_i && (state == IDLE || state == DONE);
  assign accept      = bus.req_i && bus.ready_o;
  assign new_flags   = {bus.NV_i, 1'b0, bus.OF_i, bus.UF_i, bus.NX_i};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      bus.Rounding_mode_o <= '0;
      bus.A_o             <= '0;
      bus.B_o             <= '0;
      bus.C_o             <= '0;
      bus.valid_o         <= 1'b0;
      bus.Result_o        <= '0;
      bus.flags_o         <= '0;
      bus.fflags_o        <= '0;
    end else begin
      if (bus.fflags_clr_i) bus.fflags_o <= '0;
      if (accept) begin
        bus.Rounding_mode_o <= bus.Rounding_mode_i;
        bus.A_o             <= bus.A_i;
        bus.B_o             <= bus.B_i;
        bus.C_o             <= bus.C_i;
        cnt                 <= 4'(PARM_LAT - 1);
        state               <= BUSY;
      end
      case (state)
        BUSY: if (!bus.stall_i) begin
          if (cnt == 4'd0) begin
            bus.Result_o <= bus.Result_i;
            bus.flags_o  <= new_flags;
            // a clear on the capture edge leaves only the new flags
            bus.fflags_o <= (bus.fflags_clr_i ? 5'b0 : bus.fflags_o) | new_flags;
            bus.valid_o  <= 1'b1;
            state        <= DONE;
          end else cnt <= cnt - 4'd1;
        end
        DONE: if (!bus.stall_i) begin
          bus.valid_o <= 1'b0;
          if (!bus.req_i) state <= IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mac32_issue_ctrl.sv
// tb_mac32_issue_ctrl: directed checks of handshake, latency, stall, back-to-back, sticky flags and reset
module tb_mac32_issue_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac32_issue_if ifc ();
  mac32_issue_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  // Stand-in for MAC32_top: known IEEE vectors, otherwise an xor pattern with clean flags
  always_comb begin
    ifc.Result_i = ifc.A_o ^ ifc.B_o ^ ifc.C_o;
    {ifc.NV_i, ifc.OF_i, ifc.UF_i, ifc.NX_i} = 4'b0000;
    if (ifc.A_o == 32'h3F800000 && ifc.B_o == 32'h40000000 && ifc.C_o == 32'h40400000)
      ifc.Result_i = 32'h40E00000;
    else if (ifc.A_o == 32'h0 && ifc.B_o == 32'h7F7FFFFF && ifc.C_o == 32'h40000000) begin
      ifc.Result_i = 32'h7F800000;
      {ifc.NV_i, ifc.OF_i, ifc.UF_i, ifc.NX_i} = 4'b0101;
    end else if (ifc.A_o == 32'h0 && ifc.B_o == 32'h0 && ifc.C_o == 32'h7F800000) begin
      ifc.Result_i = 32'h7FC00000;
      {ifc.NV_i, ifc.OF_i, ifc.UF_i, ifc.NX_i} = 4'b1000;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [2:0] rm);
    ifc.req_i = 1'b1; ifc.A_i = a; ifc.B_i = b; ifc.C_i = c; ifc.Rounding_mode_i = rm;
    for (int i = 0; i < 50 && !ifc.ready_o; i++) @(negedge clk);
    checks++;
    if (ifc.ready_o !== 1'b1) begin errors++; $display("FAIL issue_ready got %b want 1", ifc.ready_o); end
    @(negedge clk);
    ifc.req_i = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && ifc.valid_o !== 1'b1; i++) @(negedge clk);
    checks++;
    if (ifc.valid_o !== 1'b1) begin errors++; $display("FAIL wait_valid got %b want 1", ifc.valid_o); end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    ifc.req_i = 0; ifc.stall_i = 0; ifc.fflags_clr_i = 0; ifc.Rounding_mode_i = 0;
    ifc.A_i = 0; ifc.B_i = 0; ifc.C_i = 0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ifc.valid_o !== 1'b0 || ifc.Result_o !== 32'h0 || ifc.flags_o !== 5'h0 || ifc.fflags_o !== 5'h0)
      begin errors++; $display("FAIL reset_outputs got v=%b r=%h f=%b ff=%b want 0", ifc.valid_o, ifc.Result_o, ifc.flags_o, ifc.fflags_o); end
    checks++;
    if (ifc.A_o !== 32'h0 || ifc.B_o !== 32'h0 || ifc.C_o !== 32'h0 || ifc.Rounding_mode_o !== 3'h0)
      begin errors++; $display("FAIL reset_operands got a=%h b=%h c=%h rm=%h want 0", ifc.A_o, ifc.B_o, ifc.C_o, ifc.Rounding_mode_o); end
    checks++;
    if (ifc.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ifc.ready_o); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    issue(32'h3F800000, 32'h40000000, 32'h40400000, 3'b000);
    checks++;
    if (ifc.valid_o !== 1'b0 || ifc.A_o !== 32'h3F800000 || ifc.C_o !== 32'h40400000 || ifc.Rounding_mode_o !== 3'b000)
      begin errors++; $display("FAIL basic_load got v=%b a=%h c=%h rm=%h want 0 3f800000 40400000 0", ifc.valid_o, ifc.A_o, ifc.C_o, ifc.Rounding_mode_o); end
    @(negedge clk);
    checks++;
    if (ifc.valid_o !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", ifc.valid_o); end
    @(negedge clk);
    checks++;
    if (ifc.valid_o !== 1'b1 || ifc.Result_o !== 32'h40E00000 || ifc.flags_o !== 5'b00000 || ifc.fflags_o !== 5'b00000)
      begin errors++; $display("FAIL basic_result got v=%b r=%h f=%b ff=%b want 1 40e00000 00000 00000", ifc.valid_o, ifc.Result_o, ifc.flags_o, ifc.fflags_o); end
    @(negedge clk);
    checks++;
    if (ifc.valid_o !== 1'b0 || ifc.ready_o !== 1'b1) begin errors++; $display("FAIL basic_consume got v=%b rdy=%b want 0 1", ifc.valid_o, ifc.ready_o); end
  endtask

  task automatic test_flags();
    issue(32'h0, 32'h7F7FFFFF, 32'h40000000, 3'b000);
    wait_valid();
    checks++;
    if (ifc.Result_o !== 32'h7F800000 || ifc.flags_o !== 5'b00101 || ifc.fflags_o !== 5'b00101)
      begin errors++; $display("FAIL overflow got r=%h f=%b ff=%b want 7f800000 00101 00101", ifc.Result_o, ifc.flags_o, ifc.fflags_o); end
    @(negedge clk);
    issue(32'h0, 32'h0, 32'h7F800000, 3'b000);
    wait_valid();
    checks++;
    if (ifc.Result_o !== 32'h7FC00000 || ifc.flags_o !== 5'b10000 || ifc.fflags_o !== 5'b10101)
      begin errors++; $display("FAIL invalid got r=%h f=%b ff=%b want 7fc00000 10000 10101", ifc.Result_o, ifc.flags_o, ifc.fflags_o); end
    @(negedge clk);
    checks++;
    if (ifc.valid_o !== 1'b0 || ifc.fflags_o !== 5'b10101)
      begin errors++; $display("FAIL consume_keeps_fflags got v=%b ff=%b want 0 10101", ifc.valid_o, ifc.fflags_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
    logic [31:0] ob [3] = '{32'h0000FFFF, 32'h00FF00FF, 32'h0F0F0F0F};
    logic [31:0] oc [3] = '{32'h80000001, 32'h40000002, 32'h20000004};
    int t [3];
    int n = 0;
    logic acc;
    ifc.req_i = 1; ifc.A_i = oa[0]; ifc.B_i = ob[0]; ifc.C_i = oc[0]; ifc.Rounding_mode_i = 3'b001;
    for (int i = 0; i < 30 && n < 3; i++) begin
      acc = ifc.req_i && ifc.ready_o;
      @(posedge clk);
      #1;
      if (acc) begin
        t[n] = cyc;
        n++;
        if (n < 3) begin ifc.A_i = oa[n]; ifc.B_i = ob[n]; ifc.C_i = oc[n]; end
        else ifc.req_i = 0;
      end else if (n > 0) begin
        checks++;
        if (ifc.A_o !== oa[n-1] || ifc.B_o !== ob[n-1] || ifc.C_o !== oc[n-1])
          begin errors++; $display("FAIL b2b_operand_stable got a=%h want %h", ifc.A_o, oa[n-1]); end
      end
      @(negedge clk);
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", n); end
    else begin
      checks++;
      if (t[1] - t[0] != 3 || t[2] - t[1] != 3)
        begin errors++; $display("FAIL b2b_spacing got %0d %0d want 3 3", t[1] - t[0], t[2] - t[1]); end
    end
    wait_valid();
    checks++;
    if (ifc.Result_o !== (oa[2] ^ ob[2] ^ oc[2]) || ifc.Rounding_mode_o !== 3'b001)
      begin errors++; $display("FAIL b2b_last_result got r=%h rm=%h want %h 1", ifc.Result_o, ifc.Rounding_mode_o, oa[2] ^ ob[2] ^ oc[2]); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    ifc.stall_i = 1;
    #1;
    checks++;
    if (ifc.ready_o !== 1'b0) begin errors++; $display("FAIL idle_stall_ready got %b want 0", ifc.ready_o); end
    ifc.stall_i = 0;
    issue(32'h1, 32'h2, 32'h4, 3'b010);
    wait_valid();
    ifc.stall_i = 1;
    ifc.req_i = 1; ifc.A_i = 32'h10; ifc.B_i = 32'h20; ifc.C_i = 32'h40;
    #1;
    checks++;
    if (ifc.ready_o !== 1'b0) begin errors++; $display("FAIL done_stall_ready got %b want 0", ifc.ready_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ifc.valid_o !== 1'b1 || ifc.Result_o !== 32'h7 || ifc.flags_o !== 5'b0 || ifc.ready_o !== 1'b0 || ifc.A_o !== 32'h1)
        begin errors++; $display("FAIL stall_hold got v=%b r=%h f=%b rdy=%b a=%h want 1 7 0 0 1", ifc.valid_o, ifc.Result_o, ifc.flags_o, ifc.ready_o, ifc.A_o); end
    end
    ifc.stall_i = 0;
    @(negedge clk);
    ifc.req_i = 0;
    checks++;
    if (ifc.valid_o !== 1'b0 || ifc.A_o !== 32'h10) begin errors++; $display("FAIL stall_release got v=%b a=%h want 0 10", ifc.valid_o, ifc.A_o); end
    wait_valid();
    checks++;
    if (ifc.Result_o !== 32'h70) begin errors++; $display("FAIL stall_next_result got %h want 70", ifc.Result_o); end
    @(negedge clk);
  endtask

  task automatic test_clear();
    ifc.fflags_clr_i = 1;
    @(negedge clk);
    ifc.fflags_clr_i = 0;
    checks++;
    if (ifc.fflags_o !== 5'b0) begin errors++; $display("FAIL clear_alone got %b want 00000", ifc.fflags_o); end
    issue(32'h0, 32'h0, 32'h7F800000, 3'b000);
    wait_valid();
    checks++;
    if (ifc.fflags_o !== 5'b10000) begin errors++; $display("FAIL clear_reaccrue got %b want 10000", ifc.fflags_o); end
    @(negedge clk);
    issue(32'h0, 32'h7F7FFFFF, 32'h40000000, 3'b000);
    @(negedge clk);
    ifc.fflags_clr_i = 1;
    @(negedge clk);
    ifc.fflags_clr_i = 0;
    checks++;
    if (ifc.valid_o !== 1'b1 || ifc.fflags_o !== 5'b00101)
      begin errors++; $display("FAIL clear_on_capture got v=%b ff=%b want 1 00101", ifc.valid_o, ifc.fflags_o); end
    @(negedge clk);
  endtask

  task automatic test_reset_midbusy();
    int seen = 0;
    issue(32'h0, 32'h0, 32'h7F800000, 3'b011);
    rst_n = 0;
    #1;
    checks++;
    if (ifc.valid_o !== 1'b0 || ifc.A_o !== 32'h0 || ifc.C_o !== 32'h0 || ifc.Rounding_mode_o !== 3'h0 ||
        ifc.Result_o !== 32'h0 || ifc.flags_o !== 5'h0 || ifc.fflags_o !== 5'h0)
      begin errors++; $display("FAIL midbusy_reset got v=%b c=%h rm=%h r=%h f=%b ff=%b want all 0", ifc.valid_o, ifc.C_o, ifc.Rounding_mode_o, ifc.Result_o, ifc.flags_o, ifc.fflags_o); end
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifc.valid_o === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || ifc.ready_o !== 1'b1) begin errors++; $display("FAIL midbusy_no_valid got pulses=%0d rdy=%b want 0 1", seen, ifc.ready_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_back_to_back();
    test_stall();
    test_clear();
    test_reset_midbusy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
